uart_mem_dumper: RTL and testbench
==================================

Name: uart_mem_dumper

Overview:
Byte-stream responder that reads a memory region and streams its contents out through the UART transmit FIFO. It sits on the data clock domain beside the UART memory loader and shares the same byte-level UART interface. The loader writes memory from the host; this block reads memory back to the host. A short command header selects the region and byte count. The block then issues single-outstanding memory reads and pushes each byte to the TX FIFO under back-pressure. An 8-bit checksum trailer follows the data.

Parameters:
TIMEOUT, 24'd2000000, data_clk cycles allowed between header bytes before the header is abandoned
OPCODE, 4'hD, required value of command byte [7:4]

Ports:
clk  in  1  data clock
rst  in  1  reset, synchronous, active-high
rx_valid  in  1  one-cycle strobe: rx_data holds a received byte
rx_data  in  8  received byte
tx_full  in  1  TX FIFO full; no push allowed while high
tx_send  out  1  one-cycle push strobe to TX FIFO
tx_data  out  8  byte to push; valid while tx_send=1
rd_req  out  1  one-cycle memory read request
rd_addr  out  28  read address; held stable from rd_req until rd_valid
rd_valid  in  1  one-cycle strobe: rd_data valid; 1..N cycles after rd_req
rd_data  in  8  memory read data
dumping  out  1  high from first rd_req to checksum push inclusive

Behaviour:
- Reset: state=IDLE; tx_send=0, tx_data=0, rd_req=0, rd_addr=0, dumping=0; checksum, count, timeout counter cleared. A reset mid-dump aborts immediately. No further pushes or requests occur. A pending rd_valid after reset is ignored.
- Header: cmd, len[23:16], len[15:8], len[7:0], taken on rx_valid strobes.
- IDLE: on rx_valid with rx_data[7:4]==OPCODE, latch region=rx_data[3:0] into rd_addr[27:24], clear rd_addr[23:0], and go to LEN2. Any other byte is discarded.
- LEN2/LEN1/LEN0: each rx_valid latches one length byte, big-endian. A timeout counter is cleared on entry and on each byte. When it reaches TIMEOUT-1 without a byte, return to IDLE. Nothing is sent in that case.
- After LEN0: len==0 goes to CSUM directly; the trailer is 8'h00 and no reads occur. Otherwise go to READ.
- READ: assert rd_req for exactly 1 cycle with the current rd_addr, set dumping=1, then go to WAIT.
- WAIT: on rd_valid, capture rd_data into a hold register and go to PUSH. rd_valid outside WAIT is ignored.
- PUSH: when tx_full==0, pulse tx_send with tx_data=hold. In the same cycle, checksum += hold (mod 256) and rd_addr[23:0] += 1 (bits 27:24 unchanged). If the incremented address equals len, go to CSUM; else go to READ. While tx_full==1, hold state with no push.
- CSUM: when tx_full==0, push tx_data = two's complement of checksum. The data plus trailer then sums to 0 mod 256. Clear dumping and go to IDLE.
- Throughput: at most one byte every 3 cycles plus memory latency plus tx_full stall. Only one read is ever outstanding.
- rx_valid outside the IDLE/LEN states is ignored; no command queuing.
- len max 24'hFFFFFF. The address compare covers the full 24 bits, and wrap cannot occur before the compare matches.
- tx_send is never high in two consecutive cycles and never high while tx_full=1.

Test Plan:
- Header D3 00 00 04; memory at 0x3000000..0x3000003 = 11 22 33 44, rd latency 2 -> rd_addr sequence 3000000..3000003; TX bytes 11 22 33 44 then trailer 0x56; dumping falls after the trailer push.
- Header D0 00 00 00 -> no rd_req; single TX byte 0x00; dumping stays 0.
- Bytes 41 7F, then D1 00 00 01 -> first two bytes ignored; one read at 0x1000000, then data and trailer.
- tx_full held high 20 cycles during PUSH of the second of 3 bytes -> no tx_send while full; byte order and trailer intact; no extra rd_req.
- D2 00, then silence for TIMEOUT cycles (TIMEOUT=16 in bench), then D2 00 00 01 -> first header dropped without output; second executes one read at 0x2000000.
- rst asserted mid-transfer (after 2 of 8 bytes) with rd_valid arriving the cycle after reset -> all outputs 0, state IDLE, no further tx_send; a fresh header then works normally.

Source files
------------

// File: rtl/uart_mem_dumper_if.sv
// Byte-level UART and memory-read bundle between the dumper and its neighbours.
//
// Handshakes: rx_valid and rd_valid are single-cycle strobes with no
// back-pressure; the receiver must take the byte in that cycle or lose it.
// tx_send is a single-cycle push that is only legal while tx_full is low.
// rd_req is a single-cycle request, and rd_addr stays stable until the
// matching rd_valid arrives. Only one read is ever outstanding.
interface uart_mem_dumper_if;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        tx_full;
  logic        tx_send;
  logic [7:0]  tx_data;
  logic        rd_req;
  logic [27:0] rd_addr;
  logic        rd_valid;
  logic [7:0]  rd_data;
  logic        dumping;

  // Dumper side.
  modport master (
    input  rx_valid, rx_data, tx_full, rd_valid, rd_data,
    output tx_send, tx_data, rd_req, rd_addr, dumping
  );

  // Environment side: UART RX/TX FIFO and memory.
  modport slave (
    output rx_valid, rx_data, tx_full, rd_valid, rd_data,
    input  tx_send, tx_data, rd_req, rd_addr, dumping
  );
endinterface

// File: rtl/uart_mem_dumper.sv
// The block takes a 4-byte header (cmd, len[23:16], len[15:8], len[7:0]).
// It reads len bytes from region cmd[3:0] one at a time and pushes each byte
// to the TX FIFO. After the data it pushes a trailer that makes the sum of
// all pushed bytes equal to 0 mod 256.
module uart_mem_dumper #(
  parameter logic [23:0] TIMEOUT = 24'd2000000,
  parameter logic [3:0]  OPCODE  = 4'hD
) (
  input  logic               clk,
  input  logic               rst,
  uart_mem_dumper_if.master  bus,
  output logic [2:0]         state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LEN2 = 3'd1,
    S_LEN1 = 3'd2,
    S_LEN0 = 3'd3,
    S_READ = 3'd4,
    S_WAIT = 3'd5,
    S_PUSH = 3'd6,
    S_CSUM = 3'd7
  } state_t;

  state_t      state_q, state_d;
  logic [27:0] addr_q;
  logic [23:0] len_q;
  logic [23:0] len_next;
  logic [23:0] addr_inc;
  logic [23:0] tmo_q;
  logic        tmo_hit;
  logic [7:0]  hold_q;
  logic [7:0]  csum_q;
  logic        dump_q;
  logic        sent_q;
  logic        send;
  logic [7:0]  send_data;
  logic        req;
  logic        hdr_hit;

  assign hdr_hit  = bus.rx_valid && (bus.rx_data[7:4] == OPCODE);
  assign len_next = {len_q[15:0], bus.rx_data};
  assign addr_inc = addr_q[23:0] + 24'd1;
  assign tmo_hit  = (tmo_q == TIMEOUT - 24'd1);

  assign bus.tx_send = send;
  assign bus.tx_data = send_data;
  assign bus.rd_req  = req;
  assign bus.rd_addr = addr_q;
  assign bus.dumping = dump_q;
  assign state_dbg   = state_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state and strobe outputs; pushes are gated by tx_full.
  // The trailer also waits one cycle after the last data push.
  always_comb begin
    state_d   = state_q;
    send      = 1'b0;
    send_data = 8'h00;
    req       = 1'b0;
    case (state_q)
      S_IDLE: if (hdr_hit) state_d = S_LEN2;
      S_LEN2: begin
        if (bus.rx_valid)  state_d = S_LEN1;
        else if (tmo_hit)  state_d = S_IDLE;
      end
      S_LEN1: begin
        if (bus.rx_valid)  state_d = S_LEN0;
        else if (tmo_hit)  state_d = S_IDLE;
      end
      S_LEN0: begin
        if (bus.rx_valid)  state_d = (len_next == 24'd0) ? S_CSUM : S_READ;
        else if (tmo_hit)  state_d = S_IDLE;
      end
      S_READ: begin
        req     = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: if (bus.rd_valid) state_d = S_PUSH;
      S_PUSH: begin
        if (!bus.tx_full) begin
          send      = 1'b1;
          send_data = hold_q;
          state_d   = (addr_inc == len_q) ? S_CSUM : S_READ;
        end
      end
      S_CSUM: begin
        if (!bus.tx_full && !sent_q) begin
          send      = 1'b1;
          send_data = 8'h00 - csum_q;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: header capture, timeout, read data hold, checksum and address walk.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= 28'd0;
      len_q  <= 24'd0;
      tmo_q  <= 24'd0;
      hold_q <= 8'h00;
      csum_q <= 8'h00;
      dump_q <= 1'b0;
      sent_q <= 1'b0;
    end else begin
      sent_q <= send;
      case (state_q)
        S_IDLE: begin
          if (hdr_hit) begin
            addr_q <= {bus.rx_data[3:0], 24'd0};
            len_q  <= 24'd0;
            tmo_q  <= 24'd0;
            csum_q <= 8'h00;
          end
        end
        S_LEN2, S_LEN1, S_LEN0: begin
          if (bus.rx_valid) begin
            len_q <= len_next;
            tmo_q <= 24'd0;
          end else begin
            tmo_q <= tmo_q + 24'd1;
          end
          if (state_d == S_READ) dump_q <= 1'b1;
        end
        S_WAIT: if (bus.rd_valid) hold_q <= bus.rd_data;
        S_PUSH: begin
          if (send) begin
            csum_q       <= csum_q + hold_q;
            addr_q[23:0] <= addr_inc;
          end
        end
        S_CSUM: if (send) dump_q <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_mem_dumper.sv
// Directed bench for uart_mem_dumper. A small memory model answers reads
// after a programmable latency. A monitor collects pushed bytes and read
// addresses, and the collected values are compared with hand-computed
// expectations.
module tb_uart_mem_dumper;

  localparam logic [23:0] TMO = 24'd16;

  logic       clk;
  logic       rst;
  logic [2:0] state_dbg;

  uart_mem_dumper_if bus();

  uart_mem_dumper #(.TIMEOUT(TMO), .OPCODE(4'hD)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [7:0]  exp_q[$];
  logic [7:0]  tx_q[$];
  logic        dmp_q[$];
  logic [27:0] exp_a_q[$];
  logic [27:0] ra_q[$];
  logic [7:0]  mem [logic [27:0]];
  int          lat = 2;
  int          n_checks = 0;
  int          n_pass = 0;
  int          viol_full = 0;
  int          viol_consec = 0;
  logic        prev_send = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [7:0] mem_rd(input logic [27:0] a);
    return mem.exists(a) ? mem[a] : 8'h00;
  endfunction

  // Monitor: samples 1ns after the falling edge.
  always begin
    @(negedge clk);
    #1;
    if (bus.tx_send) begin
      tx_q.push_back(bus.tx_data);
      dmp_q.push_back(bus.dumping);
      if (bus.tx_full) viol_full++;
      if (prev_send) viol_consec++;
    end
    if (bus.rd_req) ra_q.push_back(bus.rd_addr);
    prev_send = bus.tx_send;
  end

  // Memory responder: rd_valid is sampled lat cycles after rd_req.
  initial begin
    logic [27:0] a;
    bus.rd_valid = 1'b0;
    bus.rd_data  = 8'h00;
    forever begin
      @(negedge clk);
      if (bus.rd_req) begin
        a = bus.rd_addr;
        repeat (lat - 1) @(negedge clk);
        bus.rd_valid = 1'b1;
        bus.rd_data  = mem_rd(a);
        @(negedge clk);
        bus.rd_valid = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_hdr(input logic [7:0] c, input logic [23:0] len);
    send_byte(c);
    send_byte(len[23:16]);
    send_byte(len[15:8]);
    send_byte(len[7:0]);
  endtask

  task automatic wait_tx(input string tag, input int n, input int budget);
    int k = 0;
    while (tx_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    repeat (6) @(negedge clk);
    check({tag, "_tx_count"}, tx_q.size(), n);
  endtask

  task automatic cmp_tx(input string tag);
    for (int i = 0; i < exp_q.size() && i < tx_q.size(); i++)
      check($sformatf("%s_tx[%0d]", tag, i), tx_q[i], exp_q[i]);
    for (int i = 0; i < exp_a_q.size() && i < ra_q.size(); i++)
      check($sformatf("%s_addr[%0d]", tag, i), ra_q[i], exp_a_q[i]);
    check({tag, "_rd_count"}, ra_q.size(), exp_a_q.size());
    tx_q.delete();
    dmp_q.delete();
    ra_q.delete();
    exp_q.delete();
    exp_a_q.delete();
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int k;
    rst         = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    bus.tx_full  = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    check("rst_tx_send", bus.tx_send, 0);
    check("rst_tx_data", bus.tx_data, 0);
    check("rst_rd_req", bus.rd_req, 0);
    check("rst_rd_addr", bus.rd_addr, 0);
    check("rst_dumping", bus.dumping, 0);
    check("rst_state", state_dbg, 0);
    rst = 1'b0;

    // 1: four bytes from region 3, latency 2.
    mem[28'h3000000] = 8'h11; mem[28'h3000001] = 8'h22;
    mem[28'h3000002] = 8'h33; mem[28'h3000003] = 8'h44;
    send_hdr(8'hD3, 24'd4);
    wait_tx("t1", 5, 300);
    for (int i = 0; i < dmp_q.size(); i++) check($sformatf("t1_dumping[%0d]", i), dmp_q[i], 1);
    check("t1_dumping_after", bus.dumping, 0);
    exp_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h56};
    exp_a_q = '{28'h3000000, 28'h3000001, 28'h3000002, 28'h3000003};
    cmp_tx("t1");

    // 2: zero length gives only a 00 trailer.
    send_hdr(8'hD0, 24'd0);
    wait_tx("t2", 1, 100);
    if (dmp_q.size() > 0) check("t2_dumping", dmp_q[0], 0);
    check("t2_dumping_after", bus.dumping, 0);
    exp_q = '{8'h00};
    cmp_tx("t2");

    // 3: non-command bytes are ignored.
    mem[28'h1000000] = 8'hA5;
    send_byte(8'h41);
    send_byte(8'h7F);
    check("t3_idle", state_dbg, 0);
    send_hdr(8'hD1, 24'd1);
    wait_tx("t3", 2, 200);
    exp_q = '{8'hA5, 8'h5B};
    exp_a_q = '{28'h1000000};
    cmp_tx("t3");

    // 4: TX FIFO full for 20 cycles while the second byte waits to be pushed.
    mem[28'h4000000] = 8'h10; mem[28'h4000001] = 8'h20; mem[28'h4000002] = 8'h30;
    send_hdr(8'hD4, 24'd3);
    k = 0;
    while (ra_q.size() < 2 && k < 200) begin @(negedge clk); k++; end
    bus.tx_full = 1'b1;
    repeat (20) @(negedge clk);
    #2;
    check("t4_stall_tx_count", tx_q.size(), 1);
    check("t4_stall_state", state_dbg, 6);
    check("t4_stall_rd_count", ra_q.size(), 2);
    @(negedge clk);
    bus.tx_full = 1'b0;
    wait_tx("t4", 4, 200);
    exp_q = '{8'h10, 8'h20, 8'h30, 8'hA0};
    exp_a_q = '{28'h4000000, 28'h4000001, 28'h4000002};
    cmp_tx("t4");

    // 5: header abandoned after silence, then a fresh header runs.
    mem[28'h2000000] = 8'h7E;
    send_byte(8'hD2);
    send_byte(8'h00);
    repeat (20) @(negedge clk);
    #2;
    check("t5_timeout_state", state_dbg, 0);
    check("t5_timeout_tx", tx_q.size(), 0);
    send_hdr(8'hD2, 24'd1);
    wait_tx("t5", 2, 200);
    exp_q = '{8'h7E, 8'h82};
    exp_a_q = '{28'h2000000};
    cmp_tx("t5");

    // 6: reset during an 8-byte dump; a read return arrives just after reset.
    for (int i = 0; i < 8; i++) mem[28'h5000000 + 28'(i)] = 8'(i + 1);
    lat = 3;
    send_hdr(8'hD5, 24'd8);
    k = 0;
    while (ra_q.size() < 3 && k < 300) begin @(negedge clk); k++; end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #2;
    check("t6_rst_tx_send", bus.tx_send, 0);
    check("t6_rst_tx_data", bus.tx_data, 0);
    check("t6_rst_rd_req", bus.rd_req, 0);
    check("t6_rst_rd_addr", bus.rd_addr, 0);
    check("t6_rst_dumping", bus.dumping, 0);
    check("t6_rst_state", state_dbg, 0);
    repeat (12) @(negedge clk);
    check("t6_after_state", state_dbg, 0);
    check("t6_after_tx_count", tx_q.size(), 2);
    exp_q = '{8'h01, 8'h02};
    exp_a_q = '{28'h5000000, 28'h5000001, 28'h5000002};
    cmp_tx("t6");
    lat = 2;
    mem[28'h6000000] = 8'h0F; mem[28'h6000001] = 8'hF0;
    send_hdr(8'hD6, 24'd2);
    wait_tx("t6b", 3, 200);
    exp_q = '{8'h0F, 8'hF0, 8'h01};
    exp_a_q = '{28'h6000000, 28'h6000001};
    cmp_tx("t6b");

    check("push_while_full", viol_full, 0);
    check("back_to_back_push", viol_consec, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
